motion_guard_fsm: RTL and testbench

//  Mode-driven motion-command guard for the drive path.
//  - Takes a requested speed/direction, an operating mode and two redundant obstacle-sensor pairs (front f1/f2, rear b1/b2).
//  - Emits registered, safety-filtered speed_o/dir_o.
//  - Sits between the command source and the motor driver.

---
 rtl/motion_guard_fsm.sv | 150 +++++++++++++++
 tb/tb_motion_guard_fsm.sv | 134 +++++++++++++
 2 files changed

// File: rtl/motion_guard_fsm.sv
// Motion-command guard: filters requested speed/direction against the active
// obstacle-sensor pair and operating mode, with registered outputs.
module motion_guard_fsm #(
  parameter int         CLEAR_CYCLES = 4,
  parameter logic [3:0] ECO_MAX      = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] speed,
  input  logic [3:0] dir,
  input  logic [1:0] mode,
  input  logic       f1,
  input  logic       f2,
  input  logic       b1,
  input  logic       b2,
  output logic [3:0] speed_o,
  output logic [3:0] dir_o
);

  localparam int            CW       = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLEAR_CYCLES - 1);

  localparam logic [1:0] MODE_STANDBY  = 2'd0;
  localparam logic [1:0] MODE_ECO      = 2'd2;
  localparam logic [1:0] MODE_OVERRIDE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SLOW = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [3:0]    w_speed_d;
  logic [3:0]    w_dir_d;

  logic       w_p1;
  logic       w_p2;
  logic       w_blocked;
  logic       w_warn;
  logic [3:0] w_eff;

  // Reverse travel watches the rear pair; the other pair plays no part.
  assign w_p1      = dir[3] ? b1 : f1;
  assign w_p2      = dir[3] ? b2 : f2;
  assign w_blocked = w_p1 & w_p2;
  assign w_warn    = w_p1 ^ w_p2;
  assign w_eff     = ((mode == MODE_ECO) && (speed > ECO_MAX)) ? ECO_MAX : speed;

  // State and clearance-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and clearance-count decision, highest priority first.
  always_comb begin
    w_next     = ST_IDLE;
    w_cnt_next = '0;
    if (mode == MODE_STANDBY) begin
      w_next = ST_IDLE;
    end else if (mode == MODE_OVERRIDE) begin
      w_next = ST_RUN;
    end else if (w_blocked) begin
      w_next = ST_HALT;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (w_warn) begin
            w_next = ST_HALT;
          end else if (r_cnt == CNT_LAST) begin
            w_next = ST_RUN;
          end else begin
            w_next     = ST_HALT;
            w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE, ST_RUN, ST_SLOW: begin
          if (w_warn) begin
            w_next = ST_SLOW;
          end else if (w_eff == 4'd0) begin
            w_next = ST_IDLE;
          end else begin
            w_next = ST_RUN;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // Output values to be registered, derived from the chosen next state.
  always_comb begin
    w_speed_d = 4'd0;
    w_dir_d   = 4'd0;
    if (mode == MODE_STANDBY) begin
      w_speed_d = 4'd0;
      w_dir_d   = 4'd0;
    end else if (mode == MODE_OVERRIDE) begin
      w_speed_d = speed;
      w_dir_d   = dir;
    end else begin
      case (w_next)
        ST_HALT: begin
          w_speed_d = 4'd0;
          w_dir_d   = dir;
        end
        ST_RUN: begin
          w_speed_d = w_eff;
          w_dir_d   = dir;
        end
        ST_SLOW: begin
          w_speed_d = w_eff >> 1;
          w_dir_d   = dir;
        end
        ST_IDLE: begin
          w_speed_d = 4'd0;
          w_dir_d   = dir;
        end
        default: begin
          w_speed_d = 4'd0;
          w_dir_d   = 4'd0;
        end
      endcase
    end
  end

  // Output register; reset clears the filtered command immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed_o <= 4'd0;
      dir_o   <= 4'd0;
    end else begin
      speed_o <= w_speed_d;
      dir_o   <= w_dir_d;
    end
  end

endmodule

// File: tb/tb_motion_guard_fsm.sv
// Table-driven bench for motion_guard_fsm with an expected-value queue and a
// hand-written asynchronous reset sequence in the middle of HALT.
module tb_motion_guard_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] speed = 4'd0;
  logic [3:0] dir = 4'd0;
  logic [1:0] mode = 2'd0;
  logic       f1 = 1'b0, f2 = 1'b0, b1 = 1'b0, b2 = 1'b0;
  logic [3:0] speed_o;
  logic [3:0] dir_o;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       r;
    logic [3:0] spd;
    logic [3:0] dr;
    logic [1:0] md;
    logic [3:0] sens;   // {f1,f2,b1,b2}
    logic [3:0] e_spd;
    logic [3:0] e_dir;
  } vec_t;

  typedef struct {
    logic [3:0] s;
    logic [3:0] d;
    int         id;
  } exp_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  exp_t sb[$];

  motion_guard_fsm dut (
    .clk(clk), .rst(rst), .speed(speed), .dir(dir), .mode(mode),
    .f1(f1), .f2(f2), .b1(b1), .b2(b2),
    .speed_o(speed_o), .dir_o(dir_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] spd, input logic [3:0] dr,
                              input logic [1:0] md, input logic [3:0] sens,
                              input logic [3:0] e_spd, input logic [3:0] e_dir);
    vec_t v;
    v.r = r; v.spd = spd; v.dr = dr; v.md = md; v.sens = sens;
    v.e_spd = e_spd; v.e_dir = e_dir;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s vec%0d: got %0d expected %0d", nm, id, act, exp);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    rst = v.r; speed = v.spd; dir = v.dr; mode = v.md;
    {f1, f2, b1, b2} = v.sens;
    sb.push_back('{v.e_spd, v.e_dir, id});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("speed_o", e.id, speed_o, e.s);
    chk("dir_o", e.id, dir_o, e.d);
  endtask

  initial begin
    // reset, then HALT clearance with rear pair ignored
    tbl_a.push_back(mk(1'b0, 4'd10, 4'd5, 2'd1, 4'b0000, 4'd0, 4'd0));
    tbl_a.push_back(mk(1'b0, 4'd10, 4'd5, 2'd1, 4'b0000, 4'd0, 4'd0));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd0, 4'b0000, 4'd0, 4'd0));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b1100, 4'd0, 4'd5));
    for (int i = 0; i < 3; i++) tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b0011, 4'd0, 4'd5));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b0011, 4'd10, 4'd5));
    // clear run interrupted by a single front sensor restarts the count
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b1100, 4'd0, 4'd5));
    for (int i = 0; i < 2; i++) tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b0011, 4'd0, 4'd5));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b1000, 4'd0, 4'd5));
    for (int i = 0; i < 3; i++) tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b0000, 4'd0, 4'd5));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b0000, 4'd10, 4'd5));
    // SLOW on warn, back to RUN
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd6, 2'd1, 4'b1000, 4'd5, 4'd6));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd6, 2'd1, 4'b0100, 4'd5, 4'd6));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd6, 2'd1, 4'b0000, 4'd10, 4'd6));
    // ECO ceiling and boundaries
    tbl_a.push_back(mk(1'b1, 4'd15, 4'd2, 2'd2, 4'b0000, 4'd8, 4'd2));
    tbl_a.push_back(mk(1'b1, 4'd15, 4'd2, 2'd2, 4'b0100, 4'd4, 4'd2));
    tbl_a.push_back(mk(1'b1, 4'd0,  4'd2, 2'd2, 4'b0000, 4'd0, 4'd2));
    tbl_a.push_back(mk(1'b1, 4'd9,  4'd2, 2'd2, 4'b0000, 4'd8, 4'd2));
    tbl_a.push_back(mk(1'b1, 4'd8,  4'd2, 2'd2, 4'b0000, 4'd8, 4'd2));
    tbl_a.push_back(mk(1'b1, 4'd7,  4'd3, 2'd2, 4'b0100, 4'd3, 4'd3));
    // OVERRIDE straight out of HALT, then inactive-pair and STANDBY checks
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b1100, 4'd0, 4'd5));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd3, 4'b1111, 4'd10, 4'd5));
    tbl_a.push_back(mk(1'b1, 4'd15, 4'd9, 2'd3, 4'b1111, 4'd15, 4'd9));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd1, 4'b0011, 4'd10, 4'd5));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd5, 2'd0, 4'b0000, 4'd0, 4'd0));
    // reverse: front blocked ignored, rear blocked halts
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd13, 2'd1, 4'b1100, 4'd10, 4'd13));
    tbl_a.push_back(mk(1'b1, 4'd10, 4'd13, 2'd1, 4'b0011, 4'd0, 4'd13));
    for (int i = 0; i < 2; i++) tbl_a.push_back(mk(1'b1, 4'd10, 4'd13, 2'd1, 4'b1100, 4'd0, 4'd13));
    // after reset mid-HALT, a full clearance is needed again
    tbl_b.push_back(mk(1'b0, 4'd10, 4'd13, 2'd1, 4'b0011, 4'd0, 4'd0));
    tbl_b.push_back(mk(1'b1, 4'd10, 4'd13, 2'd1, 4'b0011, 4'd0, 4'd13));
    for (int i = 0; i < 3; i++) tbl_b.push_back(mk(1'b1, 4'd10, 4'd13, 2'd1, 4'b0000, 4'd0, 4'd13));
    tbl_b.push_back(mk(1'b1, 4'd10, 4'd13, 2'd1, 4'b0000, 4'd10, 4'd13));

    for (int i = 0; i < tbl_a.size(); i++) run_vec(tbl_a[i], i);

    // asynchronous reset between edges must clear outputs without a clock
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_speed_o", 100, speed_o, 4'd0);
    chk("async_dir_o", 100, dir_o, 4'd0);

    for (int i = 0; i < tbl_b.size(); i++) run_vec(tbl_b[i], 200 + i);

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
